xbus_spy_resp: RTL and testbench
================================

XBUS_SPY_RESP -- requirements
Module: xbus_spy_resp

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning the clk cycles from accepted req to ack (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  22  xbus word address (octal).
REQ-005 SHALL have port datain  input  32  write data from the bus master.
REQ-006 SHALL have port dataout  output  32  read data to the bus master.
REQ-007 SHALL have port req  input  1  bus request, held by the master until it has seen ack.
REQ-008 SHALL have port write  input  1  1 = write cycle, 0 = read cycle; qualified by req.
REQ-009 SHALL have port ack  output  1  transfer complete.
REQ-010 SHALL have port decode  output  1  combinational: addr in 17766000..17766077.
REQ-011 SHALL have port interrupt  output  1  level interrupt to the bus interface.
REQ-012 SHALL have ports spy_in (input, 16) and spy_out (output, 16) for the spy data path.
REQ-013 SHALL have port spy_reg  output  4  spy register index (addr[3:0]).
REQ-014 SHALL have ports spy_rd and spy_wr, each an output of width 1, strobing spy register reads and writes.
REQ-015 SHALL have port attn  input  1  asynchronous-origin attention event; the block synchronizes it.

Function
REQ-016 Register map by offset addr[5:0] (octal) SHALL be:
  - 00-17: spy registers, excluding 12.
  - 12: MODE (16-bit, read/write, local only).
  - 40: INTSTAT (bit0 attn, bit1 error; write-1-to-clear).
  - 41: INTEN (2-bit, read/write).
  - 44: ERRSTAT (bit0 = access to an unmapped offset; any write clears it).
  - All other offsets: unmapped.
REQ-017 FSM SHALL have states IDLE, BUSY, DONE.
  - IDLE->BUSY: req & decode. The block SHALL latch addr, write and datain, and load the wait counter with WAIT_STATES-1.
  - BUSY: the counter decrements each cycle. At 0 the block SHALL go to DONE and perform the access exactly once.
  - DONE->IDLE: ~req.
REQ-018 ack SHALL equal (state==DONE), asserting WAIT_STATES cycles after req is sampled in IDLE and holding until req drops.
REQ-019 Read data SHALL be captured on the BUSY->DONE transition and held stable on dataout for all of DONE; bits 31:16 SHALL read 0.
REQ-020 dataout SHALL be 0 in IDLE and BUSY.
REQ-021 A spy read SHALL pulse spy_rd for the final BUSY cycle, with spy_reg valid; spy_in SHALL be sampled at that cycle's end.
REQ-022 A spy write SHALL pulse spy_wr for exactly one cycle on DONE entry, with spy_out=datain[15:0] held until the next write.
REQ-023 Local-register writes SHALL take effect on DONE entry; a held req SHALL NOT repeat the write.
REQ-024 An unmapped access SHALL set ERRSTAT bit0 and INTSTAT bit1; unmapped reads SHALL return 0 and unmapped writes SHALL be discarded.
REQ-025 attn SHALL pass a 2-flop synchronizer and a rising-edge detector; each edge SHALL set INTSTAT bit0.
REQ-026 When a set and a W1C clear of the same INTSTAT bit occur in one cycle, the set SHALL win.
REQ-027 interrupt SHALL be registered: |(INTSTAT & INTEN), one cycle after the status change.
REQ-028 A req that drops during BUSY SHALL abort the access (no side effects, no ack) and return the FSM to IDLE.
REQ-029 req with ~decode SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately force, at any time including mid-transfer:
  - FSM to IDLE and counter to 0.
  - ack, spy_rd, spy_wr and interrupt to 0.
  - dataout, spy_out, MODE, INTSTAT, INTEN, ERRSTAT and the synchronizer flops to 0.
REQ-031 After reset deasserts, a req that is already high SHALL be treated as a new request.

Structure
REQ-032 The region base 17766000, the register offsets, the INTSTAT bit positions and the FSM encodings SHALL reside in the shared xbus constants package.
REQ-033 The attn synchronizer and edge detector SHALL be one sub-module, sync_edge.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Read: WAIT_STATES=2, spy_in=16'o123456, read 17766003. Expect spy_reg=3, spy_rd for 1 cycle, ack 2 cycles after req, dataout=32'o123456 until req drops.
  - MODE: write 17766012 with 32'h0001ABCD, then read it. Expect 16'hABCD, upper half 0, no spy_wr.
  - Spy write: write 17766005 with 32'h00005A5A and hold req 10 cycles. Expect exactly one spy_wr, spy_out=16'h5A5A.
  - Interrupt: INTEN=2'b01, then a rising edge on attn. Expect INTSTAT=1 and interrupt=1. W1C 1 on the same cycle as a new edge leaves INTSTAT=1.
  - Unmapped: read 17766070. Expect dataout=0, ERRSTAT=1, INTSTAT bit1 set.
  - Abort: drop req in BUSY, then assert reset in DONE. Expect no ack and no side effects after the abort; ack=0 immediately on reset.

Source files
------------

// File: rtl/xbus_spy_resp_pkg.sv
// Shared xbus constants: responder region base, register offsets, INTSTAT bit
// positions and the transfer FSM encoding.
package xbus_spy_resp_pkg;

   localparam logic [21:0] XBUS_BASE    = 22'o17766000;
   localparam logic [5:0]  OFF_SPY_LAST = 6'o17;
   localparam logic [5:0]  OFF_MODE     = 6'o12;
   localparam logic [5:0]  OFF_INTSTAT  = 6'o40;
   localparam logic [5:0]  OFF_INTEN    = 6'o41;
   localparam logic [5:0]  OFF_ERRSTAT  = 6'o44;

   localparam int INT_ATTN_BIT = 0;
   localparam int INT_ERR_BIT  = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The responder owns one 64-word window; only the low six bits select a register.
   function automatic logic in_region(input logic [21:0] a);
      return (a[21:6] == XBUS_BASE[21:6]);
   endfunction

   // MODE sits inside the spy window and shadows that spy index.
   function automatic logic is_spy_off(input logic [5:0] off);
      return (off <= OFF_SPY_LAST) && (off != OFF_MODE);
   endfunction

endpackage

// File: rtl/xbus_spy_resp_sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a rising-edge
// detector; rise is high for one clk cycle per synchronized 0->1 transition.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // synchronizer chain plus one history flop for the edge compare
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= sig;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/xbus_spy_resp.sv
// Xbus slave for the spy port: wait-stated read/write responder with local
// MODE/INTSTAT/INTEN/ERRSTAT registers and a synchronized attention interrupt.
module xbus_spy_resp
   import xbus_spy_resp_pkg::*;
#(
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] addr,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   input  logic        req,
   input  logic        write,
   output logic        ack,
   output logic        decode,
   output logic        interrupt,
   input  logic [15:0] spy_in,
   output logic [15:0] spy_out,
   output logic [3:0]  spy_reg,
   output logic        spy_rd,
   output logic        spy_wr,
   input  logic        attn
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

   state_t      state_r, state_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        load_s, access_s;
   logic [5:0]  off_r, off_s;
   logic        write_r, wr_s;
   logic [15:0] wdata_r;
   logic [15:0] mode_r;
   logic [1:0]  intstat_r, inten_r;
   logic        errstat_r, interrupt_r;
   logic [31:0] dataout_r;
   logic [15:0] spy_out_r;
   logic        spy_wr_r, spy_rd_arm_r, spy_rd_arm_s;
   logic        is_spy_s, is_mode_s, is_intstat_s, is_inten_s, is_errstat_s, unmapped_s;
   logic [15:0] rd_data_s;
   logic        wr_acc_s, err_set_s, attn_rise_s;
   logic [1:0]  int_set_s, int_clr_s;
   logic        unused_s;

   assign unused_s = ^datain[31:16];

   sync_edge u_attn_sync (
      .clk   (clk),
      .reset (reset),
      .sig   (attn),
      .rise  (attn_rise_s)
   );

   // transfer FSM: next state, wait counter and the single access strobe
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      load_s   = 1'b0;
      access_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req && decode) begin
               state_s = ST_BUSY;
               cnt_s   = CNT_LOAD;
               load_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!req) begin
               state_s = ST_IDLE;
               cnt_s   = 4'd0;
            end else if (cnt_r == 4'd0) begin
               state_s  = ST_DONE;
               access_s = 1'b1;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         ST_DONE: begin
            if (!req) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // FSM state and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // request latch, captured once when a decoded req is accepted in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         off_r   <= 6'd0;
         write_r <= 1'b0;
         wdata_r <= 16'd0;
      end else if (load_s) begin
         off_r   <= addr[5:0];
         write_r <= write;
         wdata_r <= datain[15:0];
      end else begin
         off_r   <= off_r;
         write_r <= write_r;
         wdata_r <= wdata_r;
      end
   end

   // register decode of the latched offset and read-data mux
   always_comb begin
      is_spy_s     = is_spy_off(off_r);
      is_mode_s    = (off_r == OFF_MODE);
      is_intstat_s = (off_r == OFF_INTSTAT);
      is_inten_s   = (off_r == OFF_INTEN);
      is_errstat_s = (off_r == OFF_ERRSTAT);
      unmapped_s   = ~(is_spy_s | is_mode_s | is_intstat_s | is_inten_s | is_errstat_s);
      rd_data_s    = 16'd0;
      case (off_r)
         OFF_MODE:    rd_data_s = mode_r;
         OFF_INTSTAT: rd_data_s = {14'd0, intstat_r};
         OFF_INTEN:   rd_data_s = {14'd0, inten_r};
         OFF_ERRSTAT: rd_data_s = {15'd0, errstat_r};
         default: begin
            if (is_spy_s) begin
               rd_data_s = spy_in;
            end else begin
               rd_data_s = 16'd0;
            end
         end
      endcase
   end

   // The spy read strobe is armed one edge early so it covers the final BUSY cycle.
   assign off_s        = load_s ? addr[5:0] : off_r;
   assign wr_s         = load_s ? write : write_r;
   assign spy_rd_arm_s = (state_s == ST_BUSY) && (cnt_s == 4'd0) && is_spy_off(off_s) && !wr_s;

   // status set/clear terms; a set in the same cycle as a W1C clear wins
   always_comb begin
      wr_acc_s  = access_s & write_r;
      err_set_s = access_s & unmapped_s;
      int_set_s = 2'b00;
      int_set_s[INT_ATTN_BIT] = attn_rise_s;
      int_set_s[INT_ERR_BIT]  = err_set_s;
      if (wr_acc_s && is_intstat_s) begin
         int_clr_s = wdata_r[1:0];
      end else begin
         int_clr_s = 2'b00;
      end
   end

   // local registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r    <= 16'd0;
         inten_r   <= 2'b00;
         intstat_r <= 2'b00;
         errstat_r <= 1'b0;
      end else begin
         if (wr_acc_s && is_mode_s) mode_r <= wdata_r;
         if (wr_acc_s && is_inten_s) inten_r <= wdata_r[1:0];
         intstat_r <= (intstat_r & ~int_clr_s) | int_set_s;
         if (err_set_s) begin
            errstat_r <= 1'b1;
         end else if (wr_acc_s && is_errstat_s) begin
            errstat_r <= 1'b0;
         end else begin
            errstat_r <= errstat_r;
         end
      end
   end

   // bus-side and spy-side output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataout_r    <= 32'd0;
         spy_out_r    <= 16'd0;
         spy_wr_r     <= 1'b0;
         spy_rd_arm_r <= 1'b0;
         interrupt_r  <= 1'b0;
      end else begin
         spy_rd_arm_r <= spy_rd_arm_s;
         spy_wr_r     <= wr_acc_s & is_spy_s;
         interrupt_r  <= |(intstat_r & inten_r);
         if (wr_acc_s && is_spy_s) spy_out_r <= wdata_r;
         if (access_s) begin
            dataout_r <= write_r ? 32'd0 : {16'd0, rd_data_s};
         end else if (state_s != ST_DONE) begin
            dataout_r <= 32'd0;
         end else begin
            dataout_r <= dataout_r;
         end
      end
   end

   assign decode    = in_region(addr);
   assign ack       = (state_r == ST_DONE);
   assign dataout   = dataout_r;
   assign spy_out   = spy_out_r;
   assign spy_reg   = off_r[3:0];
   assign spy_wr    = spy_wr_r;
   // gated by req so a transfer aborted in its last BUSY cycle never strobes the spy
   assign spy_rd    = spy_rd_arm_r & req;
   assign interrupt = interrupt_r;

endmodule

// File: tb/tb_xbus_spy_resp.sv
// Self-checking bench for xbus_spy_resp: table of bus transfers with a read-data
// scoreboard, plus directed interrupt, unmapped, abort and reset sequences.
module tb_xbus_spy_resp;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [21:0] addr = 22'd0;
   logic [31:0] datain = 32'd0;
   logic [31:0] dataout;
   logic        req = 1'b0;
   logic        write = 1'b0;
   logic        ack, decode, interrupt;
   logic [15:0] spy_in = 16'd0;
   logic [15:0] spy_out;
   logic [3:0]  spy_reg;
   logic        spy_rd, spy_wr;
   logic        attn = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q[$];

   xbus_spy_resp #(.WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .addr(addr), .datain(datain), .dataout(dataout),
      .req(req), .write(write), .ack(ack), .decode(decode), .interrupt(interrupt),
      .spy_in(spy_in), .spy_out(spy_out), .spy_reg(spy_reg), .spy_rd(spy_rd),
      .spy_wr(spy_wr), .attn(attn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] a;
      logic        w;
      logic [31:0] d;
      logic [15:0] sp;
      int          hold;
      logic [31:0] exp_rd;
      int          exp_nrd;
      int          exp_nwr;
      logic [3:0]  exp_reg;
      logic [15:0] exp_spy_out;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One complete transfer, started at a negedge; ends one negedge after req drops.
   task automatic xfer(input string nm, input logic [21:0] a, input logic w,
                       input logic [31:0] d, input logic [15:0] sp, input int hold,
                       input logic [31:0] exp_rd, output int nrd, output int nwr,
                       output logic [3:0] rsel);
      int n, lat;
      logic [31:0] want;
      logic bad;
      nrd = 0; nwr = 0; rsel = 4'd0; n = 0; lat = -1; bad = 1'b0; want = 32'd0;
      sb_q.push_back(exp_rd);
      spy_in = sp; addr = a; write = w; datain = d; req = 1'b1;
      while (lat < 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (spy_rd) begin nrd++; rsel = spy_reg; end
         if (spy_wr) nwr++;
         if (ack) lat = n - 1;
      end
      if (sb_q.size() > 0) want = sb_q.pop_front();
      check({nm, "_ack_latency"}, lat, WS);
      check({nm, "_dataout"}, dataout, want);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (spy_rd) nrd++;
         if (spy_wr) nwr++;
         if (ack !== 1'b1 || dataout !== want) bad = 1'b1;
      end
      check({nm, "_hold_stable"}, 32'(bad), 32'd0);
      req = 1'b0;
      @(negedge clk);
      check({nm, "_ack_after_drop"}, 32'(ack), 32'd0);
      check({nm, "_data_after_drop"}, dataout, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int nrd, nwr, cnt;
      logic [3:0] rsel;

      vecs[0] = '{22'o17766003, 1'b0, 32'd0,          16'o123456, 2,  32'o123456,   1, 0, 4'd3,  16'h0000};
      vecs[1] = '{22'o17766012, 1'b1, 32'h0001ABCD,   16'h0000,   1,  32'd0,        0, 0, 4'd0,  16'h0000};
      vecs[2] = '{22'o17766012, 1'b0, 32'd0,          16'h1111,   1,  32'h0000ABCD, 0, 0, 4'd0,  16'h0000};
      vecs[3] = '{22'o17766005, 1'b1, 32'h00005A5A,   16'h0000,   10, 32'd0,        0, 1, 4'd0,  16'h5A5A};
      vecs[4] = '{22'o17766017, 1'b0, 32'd0,          16'hFFFF,   1,  32'h0000FFFF, 1, 0, 4'd15, 16'h5A5A};
      vecs[5] = '{22'o17766000, 1'b0, 32'd0,          16'h8001,   1,  32'h00008001, 1, 0, 4'd0,  16'h5A5A};
      vecs[6] = '{22'o17766041, 1'b1, 32'hFFFFFFFD,   16'h0000,   1,  32'd0,        0, 0, 4'd0,  16'h5A5A};
      vecs[7] = '{22'o17766041, 1'b0, 32'd0,          16'h0000,   1,  32'h00000001, 0, 0, 4'd0,  16'h5A5A};
      vecs[8] = '{22'o17766040, 1'b0, 32'd0,          16'h0000,   1,  32'h00000000, 0, 0, 4'd0,  16'h5A5A};
      vecs[9] = '{22'o17766044, 1'b0, 32'd0,          16'h0000,   1,  32'h00000000, 0, 0, 4'd0,  16'h5A5A};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dataout", dataout, 32'd0);
      check("rst_spy_out", 32'(spy_out), 32'd0);
      check("rst_strobes", 32'({spy_rd, spy_wr}), 32'd0);
      check("rst_interrupt", 32'(interrupt), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // table-driven transfers
      for (int i = 0; i < 10; i++) begin
         xfer($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].sp,
              vecs[i].hold, vecs[i].exp_rd, nrd, nwr, rsel);
         check($sformatf("vec%0d_spy_rd_count", i), nrd, vecs[i].exp_nrd);
         check($sformatf("vec%0d_spy_wr_count", i), nwr, vecs[i].exp_nwr);
         if (vecs[i].exp_nrd > 0) check($sformatf("vec%0d_spy_reg", i), 32'(rsel), 32'(vecs[i].exp_reg));
         check($sformatf("vec%0d_spy_out", i), 32'(spy_out), 32'(vecs[i].exp_spy_out));
      end

      // decode window boundaries and a req outside the window
      addr = 22'o17766000; #1 check("decode_low", 32'(decode), 32'd1);
      addr = 22'o17766077; #1 check("decode_high", 32'(decode), 32'd1);
      addr = 22'o17765777; #1 check("decode_below", 32'(decode), 32'd0);
      addr = 22'o17766100; #1 check("decode_above", 32'(decode), 32'd0);
      @(negedge clk);
      addr = 22'o17767003; write = 1'b0; req = 1'b1; cnt = 0;
      repeat (8) begin @(negedge clk); if (ack || spy_rd) cnt++; end
      check("nodecode_ignored", cnt, 0);
      req = 1'b0;
      @(negedge clk);

      // attention edge raises INTSTAT bit0 and, with INTEN=01, the interrupt
      attn = 1'b1; cnt = 0;
      while (!interrupt && cnt < 10) begin @(negedge clk); cnt++; end
      check("attn_interrupt", 32'(interrupt), 32'd1);
      check("attn_interrupt_latency", cnt, 4);
      xfer("intstat_after_edge", 22'o17766040, 1'b0, 32'd0, 16'd0, 0, 32'h1, nrd, nwr, rsel);
      attn = 1'b0;
      repeat (4) @(negedge clk);
      attn = 1'b1;
      xfer("w1c_collide", 22'o17766040, 1'b1, 32'h1, 16'd0, 0, 32'd0, nrd, nwr, rsel);
      xfer("intstat_set_wins", 22'o17766040, 1'b0, 32'd0, 16'd0, 0, 32'h1, nrd, nwr, rsel);
      attn = 1'b0;
      repeat (4) @(negedge clk);
      xfer("w1c_clear", 22'o17766040, 1'b1, 32'h1, 16'd0, 0, 32'd0, nrd, nwr, rsel);
      xfer("intstat_cleared", 22'o17766040, 1'b0, 32'd0, 16'd0, 0, 32'h0, nrd, nwr, rsel);
      check("interrupt_cleared", 32'(interrupt), 32'd0);

      // unmapped access
      xfer("unmapped_rd", 22'o17766070, 1'b0, 32'd0, 16'hBEEF, 0, 32'd0, nrd, nwr, rsel);
      check("unmapped_no_spy_rd", nrd, 0);
      xfer("errstat_set", 22'o17766044, 1'b0, 32'd0, 16'd0, 0, 32'h1, nrd, nwr, rsel);
      xfer("intstat_err", 22'o17766040, 1'b0, 32'd0, 16'd0, 0, 32'h2, nrd, nwr, rsel);
      check("err_masked", 32'(interrupt), 32'd0);
      xfer("inten_both", 22'o17766041, 1'b1, 32'h3, 16'd0, 0, 32'd0, nrd, nwr, rsel);
      check("err_interrupt", 32'(interrupt), 32'd1);
      xfer("errstat_wr", 22'o17766044, 1'b1, 32'h0, 16'd0, 0, 32'd0, nrd, nwr, rsel);
      xfer("errstat_cleared", 22'o17766044, 1'b0, 32'd0, 16'd0, 0, 32'h0, nrd, nwr, rsel);

      // abort in BUSY: no ack, no strobes, MODE untouched
      addr = 22'o17766012; write = 1'b1; datain = 32'h00001234; req = 1'b1;
      @(negedge clk);
      req = 1'b0; cnt = 0;
      repeat (6) begin @(negedge clk); if (ack || spy_wr || spy_rd) cnt++; end
      check("abort_wr_quiet", cnt, 0);
      addr = 22'o17766004; write = 1'b0; req = 1'b1;
      @(negedge clk);
      req = 1'b0; cnt = 0;
      repeat (6) begin @(negedge clk); if (ack || spy_rd) cnt++; end
      check("abort_rd_quiet", cnt, 0);
      xfer("mode_after_abort", 22'o17766012, 1'b0, 32'd0, 16'd0, 0, 32'h0000ABCD, nrd, nwr, rsel);

      // reset in DONE, then a still-held req is a new request
      check("pre_reset_interrupt", 32'(interrupt), 32'd1);
      addr = 22'o17766012; write = 1'b0; req = 1'b1; cnt = 0;
      while (!ack && cnt < 10) begin @(negedge clk); cnt++; end
      check("pre_reset_ack", 32'(ack), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("reset_ack_now", 32'(ack), 32'd0);
      check("reset_dataout_now", dataout, 32'd0);
      check("reset_spy_out_now", 32'(spy_out), 32'd0);
      check("reset_interrupt_now", 32'(interrupt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      xfer("req_after_reset", 22'o17766012, 1'b0, 32'd0, 16'd0, 0, 32'h0, nrd, nwr, rsel);
      xfer("inten_after_reset", 22'o17766041, 1'b0, 32'd0, 16'd0, 0, 32'h0, nrd, nwr, rsel);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
